regfile_sb: RTL
===============

# regfile_sb

Parametrised register file with an integrated scoreboard, successor to the fixed 8x16 LC-3 register file. It provides NREGS registers of WIDTH bits with two combinational read ports, one write port with same-cycle write-to-read bypass, and per-register busy bits that a pipelined datapath sets at issue and clears at writeback. It sits between the decode stage, which reads sources and reserves the destination, and the writeback stage, which drives the write port.

## Interface
Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 8, number of registers; power of two, 2..32.
- AW, $clog2(NREGS), register address width; derived, not overridden.
- ZERO_REG0, 0, when 1 register 0 always reads 0, its writes are ignored, and its reservations are ignored.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- LD_REG  in  1  write enable for the write port.
- DR  in  AW  write destination register.
- Data_In  in  WIDTH  write data.
- RSV  in  1  reserve request: mark register RSV_DR busy.
- RSV_DR  in  AW  register to reserve.
- SR1, SR2  in  AW  read addresses.
- SR1_Out, SR2_Out  out  WIDTH  read data, combinational.
- SR1_Busy, SR2_Busy  out  1  source register has an outstanding reservation, combinational.
- ERR  out  1  sticky; set when a reserve targets an already-busy register.

## Operation
- Storage: NREGS x WIDTH registers plus NREGS busy bits. Reset zeroes all registers, all busy bits and ERR.
- Write: if LD_REG=1, reg[DR] takes Data_In at the edge. If busy[DR]=1, busy[DR] clears at the same edge. LD_REG has priority over nothing else; there is no per-register load gating beyond the DR decode.
- Reserve: if RSV=1, busy[RSV_DR] sets at the edge.
- Reserve and write in the same cycle to the same register: busy stays set (reserve wins) and the data is written.
- Reserve to a register that is already busy, with no same-cycle write to that register: busy stays 1 and ERR sets. ERR clears only on Reset.
- Read SRn_Out:
  - If ZERO_REG0=1 and SRn=0, the output is 0.
  - Else if LD_REG=1 and DR=SRn, the output is Data_In (bypass).
  - Else the output is reg[SRn].
- Read SRn_Busy:
  - If ZERO_REG0=1 and SRn=0, the output is 0.
  - Else if LD_REG=1 and DR=SRn, the output is 0 (the value is arriving now).
  - Else the output is busy[SRn].
  - A same-cycle RSV does not affect SRn_Busy until the next cycle.
- ZERO_REG0=1: writes to and reserves of register 0 have no effect, and never set ERR.
- Reset takes priority over LD_REG and RSV in the same cycle. The outputs during the Reset cycle still follow the combinational rules above, including bypass.

## Timing
- Read latency: 0 cycles (combinational from SRn, reg, busy, LD_REG, DR, Data_In).
- Write latency: data is visible via bypass in the same cycle and via storage from the next cycle.
- Reserve latency: busy is visible on SRn_Busy one cycle after RSV.
- ERR asserts in the cycle after the offending reserve.
- Reset values: every register 0, every busy bit 0, ERR=0. In the cycle after Reset, SRn_Out=0 and SRn_Busy=0 for any address.
- A reset in the middle of a reservation drops all pending reservations. A later write to a formerly busy register is a plain write.

## Test plan
- Reset, then read every address on both ports: SR1_Out=SR2_Out=0, both busy outputs 0, ERR=0.
- Write 16'hBEEF to R5 with SR1=5 in the same cycle: SR1_Out=16'hBEEF that cycle; next cycle, with LD_REG=0, SR1_Out=16'hBEEF and SR2 on R4 reads 0.
- RSV R3, next cycle SR2=3: SR2_Busy=1. Write 16'h1234 to R3: SR2_Busy=0 and SR2_Out=16'h1234 in the write cycle, and busy stays 0 afterwards.
- Same-cycle RSV and write on R2: next cycle SR1=2 gives SR1_Busy=1 and SR1_Out equal to the written value.
- RSV R6 twice without an intervening write: ERR=1 from the cycle after the second reserve; ERR holds through later traffic until Reset.
- ZERO_REG0=1, NREGS=16, WIDTH=32: write 32'hFFFFFFFF to R0 and RSV R0, then read R0 on both ports: data 0, busy 0, ERR 0. R15 write/read of 32'hA5A5A5A5 returns the written value.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle between the decode/writeback stages and the
// scoreboarded register file.
//
// Signals (direction seen from the register file, i.e. the slave modport):
//   LD_REG   in   write enable for the write port
//   DR       in   write destination register
//   Data_In  in   write data
//   RSV      in   reserve request (mark RSV_DR busy)
//   RSV_DR   in   register to reserve
//   SR1/SR2  in   read addresses
//   SR1_Out  out  read data, port 1 (combinational)
//   SR2_Out  out  read data, port 2 (combinational)
//   SR1_Busy out  port 1 source has an outstanding reservation
//   SR2_Busy out  port 2 source has an outstanding reservation
//   ERR      out  sticky double-reservation error
interface regfile_sb_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 8
);
   localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic             LD_REG;
   logic [AW-1:0]    DR;
   logic [WIDTH-1:0] Data_In;
   logic             RSV;
   logic [AW-1:0]    RSV_DR;
   logic [AW-1:0]    SR1;
   logic [AW-1:0]    SR2;
   logic [WIDTH-1:0] SR1_Out;
   logic [WIDTH-1:0] SR2_Out;
   logic             SR1_Busy;
   logic             SR2_Busy;
   logic             ERR;

   modport master (
      output LD_REG, DR, Data_In, RSV, RSV_DR, SR1, SR2,
      input  SR1_Out, SR2_Out, SR1_Busy, SR2_Busy, ERR
   );

   modport slave (
      input  LD_REG, DR, Data_In, RSV, RSV_DR, SR1, SR2,
      output SR1_Out, SR2_Out, SR1_Busy, SR2_Busy, ERR
   );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: NREGS x WIDTH register file with two combinational read ports,
// one write port with same-cycle write-to-read bypass, and a per-register
// busy scoreboard (set by reserve at issue, cleared by write at writeback).
//
// Ports:
//   Clk    in  system clock, all state updates on the rising edge
//   Reset  in  synchronous, active-high reset (clears data, busy bits, ERR)
//   bus    slave side of regfile_sb_if (write, reserve, read and ERR signals)
//
// Parameters:
//   WIDTH      data width of each register
//   NREGS      number of registers, power of two, 2..32
//   ZERO_REG0  when 1, register 0 reads as 0 and ignores writes/reserves
module regfile_sb #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned NREGS     = 8,
   parameter bit          ZERO_REG0 = 1'b0
) (
   input logic          Clk,
   input logic          Reset,
   regfile_sb_if.slave  bus
);
   localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   // Storage and scoreboard state
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic             err_q, err_d;

   // Qualified write / reserve requests (register 0 masked when hard-wired)
   logic wr_en;
   logic rsv_en;

   function automatic logic is_r0(input logic [AW-1:0] addr);
      return ZERO_REG0 && (addr == '0);
   endfunction

   always_comb begin
      wr_en  = bus.LD_REG && !is_r0(bus.DR);
      rsv_en = bus.RSV && !is_r0(bus.RSV_DR);
   end

   // Scoreboard next state: writeback clears, then reserve sets, so a
   // same-cycle reserve and write on one register leaves it busy.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[bus.DR] = 1'b0;
      end
      if (rsv_en) begin
         busy_d[bus.RSV_DR] = 1'b1;
      end
   end

   // A reserve on an already-busy register is only legal when that
   // register's outstanding value is being written back this very cycle.
   always_comb begin
      err_d = err_q;
      if (rsv_en && busy_q[bus.RSV_DR] && !(wr_en && (bus.DR == bus.RSV_DR))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            regs_q[bus.DR] <= bus.Data_In;
         end
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   // Read ports, handled uniformly as a two-entry array
   logic [AW-1:0]    rd_addr [2];
   logic [WIDTH-1:0] rd_data [2];
   logic             rd_busy [2];

   assign rd_addr[0] = bus.SR1;
   assign rd_addr[1] = bus.SR2;

   // Bypass is taken from the raw LD_REG/DR: the hard-wired register 0
   // case is already caught by the first branch, and bypass must also work
   // during the Reset cycle.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         rd_busy[p] = 1'b0;
         if (is_r0(rd_addr[p])) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end else if (bus.LD_REG && (bus.DR == rd_addr[p])) begin
            rd_data[p] = bus.Data_In;
            rd_busy[p] = 1'b0;
         end else begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
         end
      end
   end

   assign bus.SR1_Out  = rd_data[0];
   assign bus.SR2_Out  = rd_data[1];
   assign bus.SR1_Busy = rd_busy[0];
   assign bus.SR2_Busy = rd_busy[1];
   assign bus.ERR      = err_q;
endmodule
